// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I ID stage - register file, instruction decode, immediate
//            generation, load-use hazard detection and ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        branch_taken,
  input  logic [31:0] IF_ID_pc,
  input  logic [31:0] IF_ID_inst,
  input  logic        WB_we,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_data,
  output logic        stall,
  output logic [31:0] ID_EX_pc,
  output logic [31:0] ID_EX_rs1_data,
  output logic [31:0] ID_EX_rs2_data,
  output logic [31:0] ID_EX_imm,
  output logic [4:0]  ID_EX_rs1,
  output logic [4:0]  ID_EX_rs2,
  output logic [4:0]  ID_EX_rd,
  output logic [3:0]  ID_EX_alu_op,
  output logic [9:0]  ID_EX_flags
);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  logic [31:0] r_regs [NREGS];

  logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [3:0]  r_alu_op;
  logic [9:0]  r_flags;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd_f, w_rs1_f, w_rs2_f;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_reg;
  logic        w_legal, w_nop, w_illegal;
  logic        w_uses_rs1, w_uses_rs2, w_has_rd, w_reg_we, w_use_imm;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm, w_rs1_data, w_rs2_data;
  logic [3:0]  w_alu_op;
  logic [9:0]  w_flags;
  logic        w_stall;
  logic        w_bubble;

  assign w_opcode = IF_ID_inst[6:0];
  assign w_funct3 = IF_ID_inst[14:12];
  assign w_rd_f   = IF_ID_inst[11:7];
  assign w_rs1_f  = IF_ID_inst[19:15];
  assign w_rs2_f  = IF_ID_inst[24:20];

  assign w_lui    = (w_opcode == c_OP_LUI);
  assign w_auipc  = (w_opcode == c_OP_AUIPC);
  assign w_jal    = (w_opcode == c_OP_JAL);
  assign w_jalr   = (w_opcode == c_OP_JALR);
  assign w_branch = (w_opcode == c_OP_BRANCH);
  assign w_load   = (w_opcode == c_OP_LOAD);
  assign w_store  = (w_opcode == c_OP_STORE);
  assign w_opimm  = (w_opcode == c_OP_IMM);
  assign w_reg    = (w_opcode == c_OP_REG);

  assign w_legal   = w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store | w_opimm | w_reg;
  assign w_nop     = (IF_ID_inst == 32'h0);
  assign w_illegal = ~w_legal & ~w_nop;

  assign w_uses_rs1 = w_legal & ~(w_lui | w_auipc | w_jal);
  assign w_uses_rs2 = w_reg | w_store | w_branch;
  assign w_has_rd   = w_reg | w_opimm | w_load | w_jal | w_jalr | w_lui | w_auipc;
  assign w_reg_we   = w_has_rd & (w_rd_f != 5'd0);
  assign w_use_imm  = w_legal & ~(w_reg | w_branch);

  // Unused source/destination fields are zeroed so forwarding never matches on them
  assign w_rs1 = w_uses_rs1 ? w_rs1_f : 5'd0;
  assign w_rs2 = w_uses_rs2 ? w_rs2_f : 5'd0;
  assign w_rd  = w_has_rd   ? w_rd_f  : 5'd0;

  always_comb begin
    w_imm = 32'h0;
    if (w_opimm || w_load || w_jalr)
      w_imm = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:20]};
    else if (w_store)
      w_imm = {{20{IF_ID_inst[31]}}, IF_ID_inst[31:25], IF_ID_inst[11:7]};
    else if (w_branch)
      w_imm = {{19{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[7],
               IF_ID_inst[30:25], IF_ID_inst[11:8], 1'b0};
    else if (w_lui || w_auipc)
      w_imm = {IF_ID_inst[31:12], 12'h000};
    else if (w_jal)
      w_imm = {{11{IF_ID_inst[31]}}, IF_ID_inst[31], IF_ID_inst[19:12],
               IF_ID_inst[20], IF_ID_inst[30:21], 1'b0};
  end

  always_comb begin
    w_alu_op = 4'b0000;
    if (w_reg)
      w_alu_op = {IF_ID_inst[30], w_funct3};
    else if (w_opimm)
      w_alu_op = {(w_funct3 == 3'b101) ? IF_ID_inst[30] : 1'b0, w_funct3};
    else if (w_branch)
      w_alu_op = {1'b0, w_funct3};
  end

  assign w_flags = {w_branch, w_jal, w_jalr, w_load, w_store,
                    w_reg_we, w_use_imm, w_lui, w_auipc, 1'b0};

  // Read with write-through bypass from the writeback port
  assign w_rs1_data = (w_rs1 == 5'd0)                 ? 32'h0 :
                      (WB_we && (WB_rd == w_rs1))     ? WB_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0)                 ? 32'h0 :
                      (WB_we && (WB_rd == w_rs2))     ? WB_data : r_regs[w_rs2];

  assign w_stall = ~branch_taken & r_flags[6] & (r_rd != 5'd0) &
                   ((w_uses_rs1 & (w_rs1_f == r_rd)) | (w_uses_rs2 & (w_rs2_f == r_rd)));
  assign stall   = w_stall;

  assign w_bubble = branch_taken | w_stall | ~w_legal;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'h0;
    end else if (WB_we && (WB_rd != 5'd0) && !HLT) begin
      r_regs[WB_rd] <= WB_data;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_pc       <= RESET_PC;
      r_rs1_data <= 32'h0;
      r_rs2_data <= 32'h0;
      r_imm      <= 32'h0;
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_alu_op   <= 4'd0;
      r_flags    <= 10'd0;
    end else if (!HLT) begin
      if (w_bubble) begin
        // An illegal instruction keeps its PC so the trap logic can report it
        r_pc       <= (!branch_taken && !w_stall && w_illegal) ? IF_ID_pc : 32'h0;
        r_rs1_data <= 32'h0;
        r_rs2_data <= 32'h0;
        r_imm      <= 32'h0;
        r_rs1      <= 5'd0;
        r_rs2      <= 5'd0;
        r_rd       <= 5'd0;
        r_alu_op   <= 4'd0;
        r_flags    <= {9'd0, (!branch_taken && !w_stall && w_illegal)};
      end else begin
        r_pc       <= IF_ID_pc;
        r_rs1_data <= w_rs1_data;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_rs1      <= w_rs1;
        r_rs2      <= w_rs2;
        r_rd       <= w_rd;
        r_alu_op   <= w_alu_op;
        r_flags    <= w_flags;
      end
    end
  end

  assign ID_EX_pc       = r_pc;
  assign ID_EX_rs1_data = r_rs1_data;
  assign ID_EX_rs2_data = r_rs2_data;
  assign ID_EX_imm      = r_imm;
  assign ID_EX_rs1      = r_rs1;
  assign ID_EX_rs2      = r_rs2;
  assign ID_EX_rd       = r_rd;
  assign ID_EX_alu_op   = r_alu_op;
  assign ID_EX_flags    = r_flags;

endmodule
`default_nettype wire
